frv_lsu_split: RTL and testbench
================================

FRV_LSU_SPLIT -- requirements
Module: frv_lsu_split

Interface
REQ-001 Parameter MISALIGN_EN, default 1: 1 = misaligned half/word split into two bus beats; 0 = misaligned access raises lsu_a_error with no bus activity.
REQ-002 Parameter TIMEOUT, default 0: consecutive dmem_stall cycles after which a beat is abandoned as a bus error; 0 disables; counter 8 bits wide; TIMEOUT SHALL be at most 255.
REQ-003 g_clk  in  1  single clock; all state updates on rising edge.
REQ-004 g_reset  in  1  asynchronous, active-high reset.
REQ-005 lsu_valid  in  1 / pipe_prog  in  1  request valid; pipeline advancing this cycle.
REQ-006 lsu_addr, lsu_wdata  in  32 each / lsu_load, lsu_store, lsu_byte, lsu_half, lsu_word, lsu_signed  in  1 each  operation controls; exactly one width input is set.
REQ-007 lsu_rdata  out  32 / lsu_ready, lsu_a_error, lsu_b_error, lsu_split  out  1 each  result; done; address error; bus error or timeout; current op uses two beats.
REQ-008 dmem_cen, dmem_wen  out  1 / dmem_strb  out  4 / dmem_addr, dmem_wdata  out  32 / dmem_rdata  in  32 / dmem_stall, dmem_error  in  1  memory bus; a beat completes when dmem_cen && !dmem_stall.

Function
REQ-009 States: IDLE, HI, DONE; encoding is free.
REQ-010 Definitions: off = lsu_addr[1:0]; mask = 0001 (byte), 0011 (half), 1111 (word); smask = 8-bit (mask << off); split = |smask[7:4].
REQ-011 lsu_a_error SHALL be asserted combinationally when lsu_valid && split && !MISALIGN_EN; no beat is issued; lsu_ready is asserted in the same cycle.
REQ-012 IDLE, lsu_valid, no address error: dmem_cen=1, dmem_addr={lsu_addr[31:2],2'b00}, dmem_strb=smask[3:0], dmem_wdata=lsu_wdata<<(8*off); this is the LO beat.
REQ-013 HI beat (state HI): dmem_cen=1, dmem_addr={lsu_addr[31:2],2'b00}+4 (wraps modulo 2^32), dmem_strb=smask[7:4], dmem_wdata=lsu_wdata>>(8*(4-off)).
REQ-014 dmem_wen SHALL equal lsu_store in both beats.
REQ-015 LO beat complete and split: capture dmem_rdata>>(8*off) into a low-part register and go to HI; lsu_ready stays 0.
REQ-016 Final beat complete (LO unsplit, or HI): lsu_ready=1 combinationally in that cycle.
REQ-017 Result composition: lsu_rdata = width-masked {hi-part, lo-part}; hi-part = dmem_rdata<<(8*(4-off)); unsplit ops use dmem_rdata>>(8*off) only.
REQ-018 lsu_rdata SHALL be sign-extended from bit 7 (byte) or bit 15 (half) when lsu_signed; otherwise zero-extended.
REQ-019 Final beat without pipe_prog: register lsu_rdata, lsu_b_error, lsu_a_error and go to DONE. DONE holds lsu_ready=1 and the registered values, with dmem_cen=0.
REQ-020 Any state in which lsu_ready=1 and pipe_prog=1: next state IDLE.
REQ-021 dmem_error on a completing LO beat of a split op: HI is skipped; the op finishes per REQ-016/019 with lsu_b_error=1.
REQ-022 Timeout, TIMEOUT>0: counter increments each cycle dmem_cen && dmem_stall; it clears on beat completion or state change. At count==TIMEOUT-1 with stall, the beat ends with lsu_b_error=1, and dmem_cen drops the next cycle.
REQ-023 lsu_split SHALL equal split && MISALIGN_EN && lsu_valid.
REQ-024 lsu_valid falling in HI without ready: abort to IDLE; dmem_cen drops combinationally.
REQ-025 Throughput: aligned op takes 1 cycle at zero stall; split op takes 2 cycles at zero stall.

Reset
REQ-026 While g_reset=1: state=IDLE; low-part register, result registers and timeout counter = 0; dmem_cen=0 combinationally; lsu_ready=0.
REQ-027 Reset asserted mid-operation (HI or DONE): all state is discarded; after release, the pending lsu_valid restarts at the LO beat.

Verification
REQ-028 Aligned LW, addr 0x100, rdata 0xDEADBEEF, no stall: 1-cycle ready; lsu_rdata=0xDEADBEEF; strb=1111.
REQ-029 LW addr 0x103, mem[0x100]=0x44332211, mem[0x104]=0x88776655:
  - LO beat: strb 1000.
  - HI beat: addr 0x104, strb 0111.
  - Result: lsu_rdata=0x77665544, lsu_split=1, ready in cycle 2.
REQ-030 SH addr 0x1FF, wdata 0x0000ABCD:
  - LO beat: addr 0x1FC, strb 1000, wdata 0xCD000000.
  - HI beat: addr 0x200, strb 0001, wdata 0x000000AB.
REQ-031 LB signed addr 0x2, rdata 0x00800000: lsu_rdata=0xFFFFFF80. With MISALIGN_EN=0, LH at 0x3 gives a_error=1, ready=1, no dmem_cen.
REQ-032 Split load with dmem_error on LO beat: no HI beat; b_error=1. With pipe_prog=0 the FSM enters DONE and holds ready=1 until pipe_prog=1.
REQ-033 TIMEOUT=4 with stall held high: b_error and ready asserted on the 4th stall cycle. Assert g_reset during an HI beat: dmem_cen drops immediately.

Source files
------------

// File: rtl/frv_lsu_split_if.sv
// Load/store unit bus bundle: pipeline-side request/response plus the data
// memory beat interface. The LSU core takes the slave modport; whatever drives
// requests and models memory takes the master modport.
//
// Handshake: a request is held on lsu_* while lsu_valid is high and is retired
// in the cycle where lsu_ready && pipe_prog. A memory beat is offered while
// dmem_cen is high and completes in the cycle where dmem_cen && !dmem_stall.
interface frv_lsu_split_if;
  // Pipeline request
  logic        lsu_valid;
  logic        pipe_prog;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic        lsu_load;
  logic        lsu_store;
  logic        lsu_byte;
  logic        lsu_half;
  logic        lsu_word;
  logic        lsu_signed;
  // Pipeline response
  logic [31:0] lsu_rdata;
  logic        lsu_ready;
  logic        lsu_a_error;
  logic        lsu_b_error;
  logic        lsu_split;
  // Data memory bus
  logic        dmem_cen;
  logic        dmem_wen;
  logic [3:0]  dmem_strb;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_stall;
  logic        dmem_error;
  // Sequencer state, exposed for observation
  logic [1:0]  dbg_state;

  modport slave (
    input  lsu_valid, pipe_prog, lsu_addr, lsu_wdata, lsu_load, lsu_store,
           lsu_byte, lsu_half, lsu_word, lsu_signed,
    output lsu_rdata, lsu_ready, lsu_a_error, lsu_b_error, lsu_split,
    output dmem_cen, dmem_wen, dmem_strb, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_stall, dmem_error,
    output dbg_state
  );

  modport master (
    output lsu_valid, pipe_prog, lsu_addr, lsu_wdata, lsu_load, lsu_store,
           lsu_byte, lsu_half, lsu_word, lsu_signed,
    input  lsu_rdata, lsu_ready, lsu_a_error, lsu_b_error, lsu_split,
    input  dmem_cen, dmem_wen, dmem_strb, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_stall, dmem_error,
    input  dbg_state
  );
endinterface

// File: rtl/frv_lsu_split.sv
// Load/store unit that turns a possibly misaligned byte/half/word access into
// one or two word-aligned memory beats. The LO beat covers the word holding
// lsu_addr; when the access spills past that word a HI beat covers the next
// word (address wraps at 2^32). Loads are reassembled and width/sign formatted.
// An optional stall timeout converts a stuck beat into a bus error.
// TIMEOUT must be in 0..255 (0 disables the timeout).
module frv_lsu_split #(
  parameter int unsigned MISALIGN_EN = 1,
  parameter int unsigned TIMEOUT     = 0
) (
  input logic            g_clk,
  input logic            g_reset,
  frv_lsu_split_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HI   = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam bit             MIS_ON   = (MISALIGN_EN != 0);
  localparam bit             TMO_ON   = (TIMEOUT != 0);
  localparam logic [7:0]     TMO_LAST = TMO_ON ? 8'(TIMEOUT - 1) : 8'd0;

  state_t      state_q, state_d;
  logic [31:0] lo_q;         // LO-beat read data already shifted down by off
  logic [31:0] res_rdata_q;  // result held while waiting in DONE
  logic        res_a_q;
  logic        res_b_q;
  logic [7:0]  tmo_q;

  // Request decode
  logic [1:0]  off;
  logic [3:0]  mask;
  logic [7:0]  smask;
  logic        split;
  logic        a_err;
  logic [4:0]  sh_lo;
  logic [5:0]  sh_hi;
  logic [31:0] lo_addr;
  logic [31:0] hi_addr;
  logic [31:0] rd_lo;
  logic [31:0] rd_hi;
  logic [31:0] wd_lo;
  logic [31:0] wd_hi;

  // Beat / result control
  logic        beat_on;
  logic        beat_hi;
  logic        tmo_hit;
  logic        beat_end;
  logic        beat_err;
  logic        final_beat;
  logic        go_hi;
  logic        rdy;
  logic        aerr_c;
  logic        berr_c;
  logic [31:0] rdata_c;

  // lsu_load and lsu_word carry no information beyond lsu_store/byte/half
  logic        unused_ok;
  assign unused_ok = bus.lsu_load ^ bus.lsu_word;

  // Width-mask and sign/zero extend a right-justified load value
  function automatic logic [31:0] fmt(input logic [31:0] raw, input logic is_b,
                                      input logic is_h, input logic sgn);
    logic [31:0] r;
    r = raw;
    if (is_b)      r = {{24{sgn & raw[7]}}, raw[7:0]};
    else if (is_h) r = {{16{sgn & raw[15]}}, raw[15:0]};
    return r;
  endfunction

  assign off     = bus.lsu_addr[1:0];
  assign smask   = {4'b0000, mask} << off;
  assign split   = |smask[7:4];
  assign a_err   = bus.lsu_valid && split && !MIS_ON;
  assign sh_lo   = {off, 3'b000};
  assign sh_hi   = 6'd32 - {1'b0, off, 3'b000};
  assign lo_addr = {bus.lsu_addr[31:2], 2'b00};
  assign hi_addr = lo_addr + 32'd4;
  assign rd_lo   = bus.dmem_rdata >> sh_lo;
  assign rd_hi   = bus.dmem_rdata << sh_hi;
  assign wd_lo   = bus.lsu_wdata << sh_lo;
  assign wd_hi   = bus.lsu_wdata >> sh_hi;

  // Byte-enable pattern of the access before it is shifted to its offset
  always_comb begin
    mask = 4'b1111;
    if (bus.lsu_byte)      mask = 4'b0001;
    else if (bus.lsu_half) mask = 4'b0011;
  end

  // Decide whether a beat is on the bus this cycle and which word it targets
  always_comb begin
    beat_on = 1'b0;
    beat_hi = 1'b0;
    if (!g_reset) begin
      case (state_q)
        S_IDLE: beat_on = bus.lsu_valid && !a_err;
        S_HI: begin
          beat_on = bus.lsu_valid;
          beat_hi = 1'b1;
        end
        default: beat_on = 1'b0;
      endcase
    end
  end

  // A beat ends on completion or when the stall budget runs out
  assign tmo_hit    = TMO_ON && beat_on && bus.dmem_stall && (tmo_q == TMO_LAST);
  assign beat_end   = beat_on && (!bus.dmem_stall || tmo_hit);
  assign beat_err   = tmo_hit || bus.dmem_error;
  // An errored LO beat of a split op finishes the op without a HI beat
  assign final_beat = beat_end && (beat_hi || !split || beat_err);
  assign go_hi      = beat_end && !beat_hi && split && !beat_err;

  // Result and done signalling (FSM output process)
  always_comb begin
    rdy     = 1'b0;
    aerr_c  = 1'b0;
    berr_c  = 1'b0;
    rdata_c = fmt(rd_lo, bus.lsu_byte, bus.lsu_half, bus.lsu_signed);
    case (state_q)
      S_IDLE: begin
        if (a_err) begin
          rdy    = 1'b1;
          aerr_c = 1'b1;
        end else if (final_beat) begin
          rdy    = 1'b1;
          berr_c = beat_err;
        end
      end
      S_HI: begin
        rdata_c = fmt(lo_q | rd_hi, bus.lsu_byte, bus.lsu_half, bus.lsu_signed);
        if (final_beat) begin
          rdy    = 1'b1;
          berr_c = beat_err;
        end
      end
      S_DONE: begin
        rdy     = 1'b1;
        aerr_c  = res_a_q;
        berr_c  = res_b_q;
        rdata_c = res_rdata_q;
      end
      default: rdy = 1'b0;
    endcase
    if (g_reset) rdy = 1'b0;
  end

  // Next-state: LO->HI on a clean split LO beat, retire on ready, abort HI on valid drop
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (go_hi) state_d = S_HI;
      S_HI:    if (!bus.lsu_valid) state_d = S_IDLE;
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
    if (rdy) state_d = bus.pipe_prog ? S_IDLE : S_DONE;
  end

  // State register
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Capture LO read data for reassembly and hold results while the pipe is stalled
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      lo_q        <= 32'd0;
      res_rdata_q <= 32'd0;
      res_a_q     <= 1'b0;
      res_b_q     <= 1'b0;
    end else begin
      if (go_hi) lo_q <= rd_lo;
      if (rdy && !bus.pipe_prog && (state_q != S_DONE)) begin
        res_rdata_q <= rdata_c;
        res_a_q     <= aerr_c;
        res_b_q     <= berr_c;
      end
    end
  end

  // Count consecutive stalled cycles of the current beat
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset)                                          tmo_q <= 8'd0;
    else if (!TMO_ON)                                     tmo_q <= 8'd0;
    else if (!beat_on || beat_end || (state_d != state_q)) tmo_q <= 8'd0;
    else                                                  tmo_q <= tmo_q + 8'd1;
  end

  assign bus.dmem_cen    = beat_on;
  assign bus.dmem_wen    = bus.lsu_store;
  assign bus.dmem_addr   = beat_hi ? hi_addr : lo_addr;
  assign bus.dmem_strb   = beat_hi ? smask[7:4] : smask[3:0];
  assign bus.dmem_wdata  = beat_hi ? wd_hi : wd_lo;
  assign bus.lsu_ready   = rdy;
  assign bus.lsu_rdata   = rdata_c;
  assign bus.lsu_a_error = aerr_c;
  assign bus.lsu_b_error = berr_c;
  assign bus.lsu_split   = split && MIS_ON && bus.lsu_valid;
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_frv_lsu_split.sv
// Bench for frv_lsu_split: directed load/store vectors against a two-word
// memory model, with an expected-beat queue and an expected-response queue
// drained by a monitor on the falling clock edge.
module tb_frv_lsu_split;

  logic g_clk = 1'b0;
  logic g_reset;
  always #5 g_clk = ~g_clk;

  frv_lsu_split_if bif ();
  frv_lsu_split_if bif_b ();

  frv_lsu_split #(.MISALIGN_EN(1), .TIMEOUT(4)) dut (
    .g_clk(g_clk), .g_reset(g_reset), .bus(bif)
  );
  frv_lsu_split #(.MISALIGN_EN(0), .TIMEOUT(0)) dut_b (
    .g_clk(g_clk), .g_reset(g_reset), .bus(bif_b)
  );

  // Memory model: mem_hi answers at mem_hi_addr, mem_lo everywhere else
  logic [31:0] mem_lo, mem_hi, mem_hi_addr;
  logic        stall, err_lo;
  assign bif.dmem_rdata   = (bif.dmem_addr == mem_hi_addr) ? mem_hi : mem_lo;
  assign bif.dmem_stall   = stall;
  assign bif.dmem_error   = err_lo && (bif.dmem_addr != mem_hi_addr);
  assign bif_b.dmem_rdata = 32'h0;
  assign bif_b.dmem_stall = 1'b0;
  assign bif_b.dmem_error = 1'b0;

  int total = 0;
  int bad   = 0;
  int mon_lat = 0;

  // beat: {addr, strb, wen, wdata}
  logic [68:0] beat_q[$];
  // resp: {chk_rdata, rdata, a_err, b_err, split, latency(0 = don't care)}
  logic [43:0] resp_q[$];

  task automatic exp_beat(input logic [31:0] a, input logic [3:0] s,
                          input logic w, input logic [31:0] d);
    beat_q.push_back({a, s, w, d});
  endtask

  task automatic exp_resp(input logic chk, input logic [31:0] rd, input logic ae,
                          input logic be, input logic sp, input logic [7:0] lat);
    resp_q.push_back({chk, rd, ae, be, sp, lat});
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // w: 0 byte, 1 half, 2 word
  task automatic set_op(input logic [31:0] addr, input logic [31:0] wdata,
                        input logic st, input int w, input logic sgn);
    bif.lsu_valid  = 1'b1;
    bif.lsu_addr   = addr;
    bif.lsu_wdata  = wdata;
    bif.lsu_load   = !st;
    bif.lsu_store  = st;
    bif.lsu_byte   = (w == 0);
    bif.lsu_half   = (w == 1);
    bif.lsu_word   = (w == 2);
    bif.lsu_signed = sgn;
  endtask

  // Issue one op with pipe_prog high; stall the first stall_n cycles
  task automatic run_op(input logic [31:0] addr, input logic [31:0] wdata,
                        input logic st, input int w, input logic sgn, input int stall_n);
    bit done;
    done = 1'b0;
    @(posedge g_clk); #1;
    set_op(addr, wdata, st, w, sgn);
    bif.pipe_prog = 1'b1;
    stall = (stall_n > 0);
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge g_clk);
      if (bif.lsu_ready && bif.pipe_prog) done = 1'b1;
      else begin
        @(posedge g_clk); #1;
        if (n + 1 >= stall_n) stall = 1'b0;
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL ready_wait addr=%h got=no_ready want=ready", addr);
    end
    @(posedge g_clk); #1;
    bif.lsu_valid = 1'b0;
    stall = 1'b0;
  endtask

  // Monitor: pop and compare on every completed beat and every retired op
  always @(negedge g_clk) begin
    logic [68:0] eb, gb;
    logic [43:0] er;
    bit ok;
    if (!g_reset) begin
      if (bif.dmem_cen && !bif.dmem_stall) begin
        total++;
        gb = {bif.dmem_addr, bif.dmem_strb, bif.dmem_wen, bif.dmem_wdata};
        if (beat_q.size() == 0) begin
          bad++;
          $display("FAIL beat_unexpected got addr=%h strb=%b want=none", bif.dmem_addr, bif.dmem_strb);
        end else begin
          eb = beat_q.pop_front();
          if (gb !== eb) begin
            bad++;
            $display("FAIL beat got addr=%h strb=%b wen=%b wdata=%h want addr=%h strb=%b wen=%b wdata=%h",
                     gb[68:37], gb[36:33], gb[32], gb[31:0], eb[68:37], eb[36:33], eb[32], eb[31:0]);
          end
        end
      end
      if (bif.lsu_valid) mon_lat++;
      if (bif.lsu_ready && bif.pipe_prog) begin
        total++;
        if (resp_q.size() == 0) begin
          bad++;
          $display("FAIL resp_unexpected got rdata=%h want=none", bif.lsu_rdata);
        end else begin
          er = resp_q.pop_front();
          ok = (bif.lsu_a_error === er[10]) && (bif.lsu_b_error === er[9]) &&
               (bif.lsu_split === er[8]) &&
               (!er[43] || (bif.lsu_rdata === er[42:11])) &&
               ((er[7:0] == 8'd0) || (mon_lat == int'(er[7:0])));
          if (!ok) begin
            bad++;
            $display("FAIL resp got rdata=%h a=%b b=%b split=%b lat=%0d want rdata=%h a=%b b=%b split=%b lat=%0d",
                     bif.lsu_rdata, bif.lsu_a_error, bif.lsu_b_error, bif.lsu_split, mon_lat,
                     er[42:11], er[10], er[9], er[8], er[7:0]);
          end
        end
        mon_lat = 0;
      end
      if (!bif.lsu_valid) mon_lat = 0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=stuck want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit done;
    // Reset with a request pending: no beat, no ready
    g_reset = 1'b1;
    stall = 1'b0; err_lo = 1'b0;
    mem_lo = 32'h0; mem_hi = 32'h0; mem_hi_addr = 32'h104;
    set_op(32'h100, 32'h0, 1'b0, 2, 1'b0);
    bif.pipe_prog = 1'b1;
    bif_b.lsu_valid = 1'b1; bif_b.pipe_prog = 1'b1;
    bif_b.lsu_addr = 32'h100; bif_b.lsu_wdata = 32'h0;
    bif_b.lsu_load = 1'b1; bif_b.lsu_store = 1'b0; bif_b.lsu_byte = 1'b0;
    bif_b.lsu_half = 1'b0; bif_b.lsu_word = 1'b1; bif_b.lsu_signed = 1'b0;
    #12;
    check("rst_cen", {31'd0, bif.dmem_cen}, 32'd0);
    check("rst_ready", {31'd0, bif.lsu_ready}, 32'd0);
    check("rst_cen_b", {31'd0, bif_b.dmem_cen}, 32'd0);
    @(posedge g_clk); #1;
    bif.lsu_valid = 1'b0; bif_b.lsu_valid = 1'b0;
    g_reset = 1'b0;

    // Aligned LW
    mem_lo = 32'hDEADBEEF; mem_hi_addr = 32'h104;
    exp_beat(32'h100, 4'b1111, 1'b0, 32'h0);
    exp_resp(1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 8'd1);
    run_op(32'h100, 32'h0, 1'b0, 2, 1'b0, 0);

    // Misaligned LW at offset 3
    mem_lo = 32'h44332211; mem_hi = 32'h88776655; mem_hi_addr = 32'h104;
    exp_beat(32'h100, 4'b1000, 1'b0, 32'h0);
    exp_beat(32'h104, 4'b0111, 1'b0, 32'h0);
    exp_resp(1'b1, 32'h77665544, 1'b0, 1'b0, 1'b1, 8'd2);
    run_op(32'h103, 32'h0, 1'b0, 2, 1'b0, 0);

    // Misaligned SH crossing into 0x200
    mem_hi_addr = 32'h200;
    exp_beat(32'h1FC, 4'b1000, 1'b1, 32'hCD000000);
    exp_beat(32'h200, 4'b0001, 1'b1, 32'h000000AB);
    exp_resp(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 8'd2);
    run_op(32'h1FF, 32'h0000ABCD, 1'b1, 1, 1'b0, 0);

    // Signed LB at offset 2
    mem_lo = 32'h00800000; mem_hi_addr = 32'h4;
    exp_beat(32'h0, 4'b0100, 1'b0, 32'h0);
    exp_resp(1'b1, 32'hFFFFFF80, 1'b0, 1'b0, 1'b0, 8'd1);
    run_op(32'h2, 32'h0, 1'b0, 0, 1'b1, 0);

    // Unsigned LH at offset 2
    mem_lo = 32'h80001234;
    exp_beat(32'h0, 4'b1100, 1'b0, 32'h0);
    exp_resp(1'b1, 32'h00008000, 1'b0, 1'b0, 1'b0, 8'd1);
    run_op(32'h2, 32'h0, 1'b0, 1, 1'b0, 0);

    // Signed split LH at offset 3
    mem_lo = 32'hAA000000; mem_hi = 32'h000000F1; mem_hi_addr = 32'h8;
    exp_beat(32'h4, 4'b1000, 1'b0, 32'h0);
    exp_beat(32'h8, 4'b0001, 1'b0, 32'h0);
    exp_resp(1'b1, 32'hFFFFF1AA, 1'b0, 1'b0, 1'b1, 8'd2);
    run_op(32'h7, 32'h0, 1'b0, 1, 1'b1, 0);

    // Split LW wrapping past the top of the address space
    mem_lo = 32'hBBAA0000; mem_hi = 32'h0000DDCC; mem_hi_addr = 32'h0;
    exp_beat(32'hFFFFFFFC, 4'b1100, 1'b0, 32'h0);
    exp_beat(32'h0, 4'b0011, 1'b0, 32'h0);
    exp_resp(1'b1, 32'hDDCCBBAA, 1'b0, 1'b0, 1'b1, 8'd2);
    run_op(32'hFFFFFFFE, 32'h0, 1'b0, 2, 1'b0, 0);

    // Aligned SW and top-byte SB
    mem_hi_addr = 32'h14;
    exp_beat(32'h10, 4'b1111, 1'b1, 32'h12345678);
    exp_resp(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 8'd1);
    run_op(32'h10, 32'h12345678, 1'b1, 2, 1'b0, 0);
    exp_beat(32'h10, 4'b1000, 1'b1, 32'hA5000000);
    exp_resp(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 8'd1);
    run_op(32'h13, 32'h000000A5, 1'b1, 0, 1'b0, 0);

    // Two stall cycles, below the timeout
    mem_lo = 32'h0BADF00D; mem_hi_addr = 32'h104;
    exp_beat(32'h100, 4'b1111, 1'b0, 32'h0);
    exp_resp(1'b1, 32'h0BADF00D, 1'b0, 1'b0, 1'b0, 8'd3);
    run_op(32'h100, 32'h0, 1'b0, 2, 1'b0, 2);

    // Stall held: timeout ends the beat on the 4th stall cycle
    exp_resp(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 8'd4);
    run_op(32'h100, 32'h0, 1'b0, 2, 1'b0, 100);

    // Bus error on the LO beat of a split load, pipeline held: DONE
    mem_lo = 32'h44332211; mem_hi = 32'h88776655; mem_hi_addr = 32'h104;
    exp_beat(32'h100, 4'b1000, 1'b0, 32'h0);
    exp_resp(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 8'd0);
    @(posedge g_clk); #1;
    err_lo = 1'b1;
    set_op(32'h103, 32'h0, 1'b0, 2, 1'b0);
    bif.pipe_prog = 1'b0;
    @(negedge g_clk);
    check("err_lo_ready", {30'd0, bif.lsu_ready, bif.lsu_b_error}, 32'd3);
    for (int i = 0; i < 3; i++) begin
      @(negedge g_clk);
      check("done_hold", {29'd0, bif.lsu_ready, bif.lsu_b_error, bif.dmem_cen}, 32'd6);
    end
    @(posedge g_clk); #1;
    bif.pipe_prog = 1'b1;
    @(posedge g_clk); #1;
    bif.lsu_valid = 1'b0;
    err_lo = 1'b0;

    // Reset during the HI beat, then the held request restarts at LO
    exp_beat(32'h100, 4'b1000, 1'b0, 32'h0);
    exp_beat(32'h100, 4'b1000, 1'b0, 32'h0);
    exp_beat(32'h104, 4'b0111, 1'b0, 32'h0);
    exp_resp(1'b1, 32'h77665544, 1'b0, 1'b0, 1'b1, 8'd0);
    @(posedge g_clk); #1;
    set_op(32'h103, 32'h0, 1'b0, 2, 1'b0);
    @(posedge g_clk); #1;
    stall = 1'b1;
    #2;
    check("hi_before_rst_cen", {31'd0, bif.dmem_cen}, 32'd1);
    g_reset = 1'b1;
    #1;
    check("rst_hi_cen", {31'd0, bif.dmem_cen}, 32'd0);
    check("rst_hi_ready", {31'd0, bif.lsu_ready}, 32'd0);
    @(posedge g_clk); #1;
    g_reset = 1'b0;
    stall = 1'b0;
    done = 1'b0;
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge g_clk);
      if (bif.lsu_ready) done = 1'b1;
    end
    check("restart_done", {31'd0, done}, 32'd1);
    @(posedge g_clk); #1;
    bif.lsu_valid = 1'b0;

    // MISALIGN_EN=0: split LH faults with no bus activity; aligned LH proceeds
    @(posedge g_clk); #1;
    bif_b.lsu_valid = 1'b1; bif_b.lsu_addr = 32'h3;
    bif_b.lsu_word = 1'b0; bif_b.lsu_half = 1'b1;
    #1;
    check("b_aerr", {28'd0, bif_b.lsu_a_error, bif_b.lsu_ready, bif_b.dmem_cen, bif_b.lsu_split}, 32'hC);
    @(posedge g_clk); #1;
    bif_b.lsu_addr = 32'h2;
    #1;
    check("b_aligned_ctl", {29'd0, bif_b.lsu_a_error, bif_b.dmem_cen, bif_b.lsu_ready}, 32'd3);
    check("b_aligned_strb", {28'd0, bif_b.dmem_strb}, 32'hC);
    @(posedge g_clk); #1;
    bif_b.lsu_valid = 1'b0;

    repeat (3) @(posedge g_clk);
    check("beat_q_left", beat_q.size(), 32'd0);
    check("resp_q_left", resp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
